wdg_wb_master: RTL and testbench



---
 rtl/wdg_wb_master.sv | 195 +++++++++++++++++++
 tb/tb_wdg_wb_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wdg_wb_master.sv
// Wishbone pipelined initiator: one register read/write per command, answered on a response channel.
// Optional feature macro: WDG_WBM_RETRY_EN (re-issue on rty up to MAX_RETRIES times).
//
// state  | meaning
// IDLE   | ready for a command; bus idle
// REQ    | cyc=1, stb=1 until the slave takes the strobe (stall=0)
// WAIT   | cyc=1, stb=0; waiting for ack/err/rty or timeout
// GAP    | cyc=1, stb=0 for one cycle before re-issuing after rty (retry build only)
// RESP   | response valid; held until consumed

module wdg_wb_master #(
    parameter int ADDRESS_WIDTH  = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_we,
    input  logic [ADDRESS_WIDTH-1:0] i_cmd_adr,
    input  logic [DATA_WIDTH-1:0]    i_cmd_dat,
    input  logic [3:0]               i_cmd_sel,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [DATA_WIDTH-1:0]    o_rsp_dat,
    output logic [1:0]               o_rsp_status,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic                     o_wb_we,
    output logic [ADDRESS_WIDTH-1:0] o_wb_adr,
    output logic [DATA_WIDTH-1:0]    o_wb_dat,
    output logic [3:0]               o_wb_sel,
    input  logic                     i_wb_stall,
    input  logic                     i_wb_ack,
    input  logic                     i_wb_err,
    input  logic                     i_wb_rty,
    input  logic [DATA_WIDTH-1:0]    i_wb_dat
);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_RETRY   = 2'b11;

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam int CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LOAD = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

`ifdef WDG_WBM_RETRY_EN
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_GAP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
`endif

    state_t                   state, state_d;
    logic                     we_q;
    logic [ADDRESS_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0]    dat_q;
    logic [3:0]               sel_q;
    logic [DATA_WIDTH-1:0]    rsp_dat_q, rsp_dat_d;
    logic [1:0]               rsp_status_q, rsp_status_d;
    logic [CW-1:0]            to_cnt;
    logic                     accept;
    logic                     term_live;
    logic                     timeout_hit;
    logic                     bus_active;

`ifdef WDG_WBM_RETRY_EN
    logic [RW-1:0]            retry_cnt;
    logic                     retry_inc;
`endif

    assign accept      = (state == S_IDLE) && i_cmd_valid;
    assign bus_active  = (state == S_REQ) || (state == S_WAIT);
    // A termination only counts once the strobe has actually been taken by the slave.
    assign term_live   = ((state == S_REQ) && !i_wb_stall) || (state == S_WAIT);
    assign timeout_hit = TO_EN && (to_cnt == '0);

    always_comb begin
        state_d      = state;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
`ifdef WDG_WBM_RETRY_EN
        retry_inc    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (i_cmd_valid) state_d = S_REQ;
            end
            S_REQ, S_WAIT: begin
                if (term_live && i_wb_err) begin
                    rsp_status_d = ST_ERR;
                    rsp_dat_d    = '0;
                    state_d      = S_RESP;
                end else if (term_live && i_wb_rty) begin
`ifdef WDG_WBM_RETRY_EN
                    if (retry_cnt == RW'(MAX_RETRIES)) begin
                        rsp_status_d = ST_RETRY;
                        rsp_dat_d    = '0;
                        state_d      = S_RESP;
                    end else begin
                        retry_inc = 1'b1;
                        state_d   = S_GAP;
                    end
`else
                    rsp_status_d = ST_RETRY;
                    rsp_dat_d    = '0;
                    state_d      = S_RESP;
`endif
                end else if (term_live && i_wb_ack) begin
                    rsp_status_d = ST_OK;
                    rsp_dat_d    = we_q ? '0 : i_wb_dat;
                    state_d      = S_RESP;
                end else if (timeout_hit) begin
                    rsp_status_d = ST_TIMEOUT;
                    rsp_dat_d    = '0;
                    state_d      = S_RESP;
                end else if ((state == S_REQ) && !i_wb_stall) begin
                    state_d = S_WAIT;
                end
            end
`ifdef WDG_WBM_RETRY_EN
            S_GAP: begin
                state_d = S_REQ;
            end
`endif
            S_RESP: begin
                if (i_rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state        <= S_IDLE;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            rsp_dat_q    <= '0;
            rsp_status_q <= '0;
            to_cnt       <= '0;
        end else begin
            state        <= state_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
            if (accept) begin
                we_q  <= i_cmd_we;
                adr_q <= i_cmd_adr;
                dat_q <= i_cmd_dat;
                sel_q <= i_cmd_sel;
            end
            // Down-counter reloads on every entry to REQ, so each re-issue gets a full window.
            if ((state_d == S_REQ) && (state != S_REQ)) begin
                to_cnt <= TO_LOAD;
            end else if (bus_active && (to_cnt != '0)) begin
                to_cnt <= to_cnt - 1'b1;
            end
        end
    end

`ifdef WDG_WBM_RETRY_EN
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            retry_cnt <= '0;
        end else if (accept) begin
            retry_cnt <= '0;
        end else if (retry_inc) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        o_wb_cyc = bus_active;
`ifdef WDG_WBM_RETRY_EN
        if (state == S_GAP) o_wb_cyc = 1'b1;
`endif
    end

    assign o_wb_stb     = (state == S_REQ);
    assign o_wb_we      = o_wb_cyc ? we_q  : 1'b0;
    assign o_wb_adr     = o_wb_cyc ? adr_q : '0;
    assign o_wb_dat     = o_wb_cyc ? dat_q : '0;
    assign o_wb_sel     = o_wb_cyc ? sel_q : '0;
    assign o_cmd_ready  = (state == S_IDLE);
    assign o_rsp_valid  = (state == S_RESP);
    assign o_rsp_dat    = o_rsp_valid ? rsp_dat_q    : '0;
    assign o_rsp_status = o_rsp_valid ? rsp_status_q : '0;

endmodule

// File: tb/tb_wdg_wb_master.sv
// Directed bench for wdg_wb_master: small Wishbone slave model plus hand-computed expectations.
// Expectations for the rty case follow WDG_WBM_RETRY_EN.

module tb_wdg_wb_master;

    localparam int AW = 2;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          res_n = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic          i_cmd_we = 1'b0;
    logic [AW-1:0] i_cmd_adr = '0;
    logic [DW-1:0] i_cmd_dat = '0;
    logic [3:0]    i_cmd_sel = '0;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b1;
    logic [DW-1:0] o_rsp_dat;
    logic [1:0]    o_rsp_status;
    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_adr;
    logic [DW-1:0] o_wb_dat;
    logic [3:0]    o_wb_sel;
    logic          i_wb_stall = 1'b0;
    logic          i_wb_ack = 1'b0;
    logic          i_wb_err = 1'b0;
    logic          i_wb_rty = 1'b0;
    logic [DW-1:0] i_wb_dat = '0;

    wdg_wb_master #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(8),
        .MAX_RETRIES   (3)
    ) dut (
        .clk         (clk),
        .res_n       (res_n),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_we    (i_cmd_we),
        .i_cmd_adr   (i_cmd_adr),
        .i_cmd_dat   (i_cmd_dat),
        .i_cmd_sel   (i_cmd_sel),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_dat   (o_rsp_dat),
        .o_rsp_status(o_rsp_status),
        .o_wb_cyc    (o_wb_cyc),
        .o_wb_stb    (o_wb_stb),
        .o_wb_we     (o_wb_we),
        .o_wb_adr    (o_wb_adr),
        .o_wb_dat    (o_wb_dat),
        .o_wb_sel    (o_wb_sel),
        .i_wb_stall  (i_wb_stall),
        .i_wb_ack    (i_wb_ack),
        .i_wb_err    (i_wb_err),
        .i_wb_rty    (i_wb_rty),
        .i_wb_dat    (i_wb_dat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave model: mode 0 = never answers, 1 = ack, 2 = err+ack together, 3 = rty.
    int            slv_mode  = 1;
    int            stall_cfg = 0;
    int            stall_left = 0;
    bit            pending = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          force_ack = 1'b0;

    always @(negedge clk) begin
        if (!res_n) begin
            i_wb_stall = 1'b0;
            i_wb_ack   = 1'b0;
            i_wb_err   = 1'b0;
            i_wb_rty   = 1'b0;
            pending    = 1'b0;
            stall_left = stall_cfg;
        end else begin
            i_wb_dat = rdata;
            if (!o_wb_cyc) stall_left = stall_cfg;
            i_wb_ack = (pending && (slv_mode == 1 || slv_mode == 2)) || force_ack;
            i_wb_err = pending && (slv_mode == 2);
            i_wb_rty = pending && (slv_mode == 3);
            pending  = 1'b0;
            if (o_wb_stb) begin
                if (stall_left > 0) begin
                    i_wb_stall = 1'b1;
                    stall_left--;
                end else begin
                    i_wb_stall = 1'b0;
                    pending    = 1'b1;
                end
            end else begin
                i_wb_stall = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and follow it until the response appears.
    // Cycle n=1 is the first cycle after the accepting edge.
    task automatic txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [3:0] sel, output int stbs, output int rsp_n,
                       output int cyc_last, output bit fields_ok);
        stbs = 0; rsp_n = 0; cyc_last = 0; fields_ok = 1'b1;
        i_cmd_valid = 1'b1;
        i_cmd_we    = we;
        i_cmd_adr   = adr;
        i_cmd_dat   = dat;
        i_cmd_sel   = sel;
        chk("cmd_ready_idle", o_cmd_ready, 1);
        tick();
        i_cmd_valid = 1'b0;
        i_cmd_we    = ~we;
        i_cmd_adr   = ~adr;
        i_cmd_dat   = ~dat;
        i_cmd_sel   = ~sel;
        for (int n = 1; n <= 100; n++) begin
            if (o_wb_stb) begin
                stbs++;
                if (o_wb_we !== we || o_wb_adr !== adr || o_wb_sel !== sel ||
                    (we && o_wb_dat !== dat)) fields_ok = 1'b0;
            end
            if (o_wb_cyc) cyc_last = n;
            if (o_rsp_valid) begin
                rsp_n = n;
                break;
            end
            tick();
        end
        chk("rsp_seen", o_rsp_valid, 1);
    endtask

    int stbs, rsp_n, cyc_last;
    bit fields_ok;
    logic [DW-1:0] held_dat;
    logic [1:0]    held_st;

    initial begin
        #200000;
        $display("FAIL tb_watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        res_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", o_cmd_ready, 1);
        chk("rst_cyc", o_wb_cyc, 0);
        chk("rst_stb", o_wb_stb, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        res_n = 1'b1;
        tick();
        chk("post_rst_cmd_ready", o_cmd_ready, 1);
        chk("post_rst_rsp_status", o_rsp_status, 0);
        chk("post_rst_wb_adr", o_wb_adr, 0);

        // Zero-wait write
        slv_mode = 1; stall_cfg = 0; rdata = 32'hDEAD_BEEF;
        txn(1'b1, 2'd0, 32'h0000_0401, 4'hF, stbs, rsp_n, cyc_last, fields_ok);
        chk("wr_stbs", stbs, 1);
        chk("wr_fields", fields_ok, 1);
        chk("wr_rsp_latency", rsp_n, 3);
        chk("wr_cyc_last", cyc_last, 2);
        chk("wr_status", o_rsp_status, 2'b00);
        chk("wr_dat", o_rsp_dat, 0);
        chk("wr_cmd_ready_busy", o_cmd_ready, 0);
        tick();
        chk("wr_consumed", o_rsp_valid, 0);

        // Read with two stall cycles
        stall_cfg = 2; rdata = 32'h0000_0123;
        txn(1'b0, 2'd2, 32'h0, 4'hF, stbs, rsp_n, cyc_last, fields_ok);
        chk("rd_stbs", stbs, 3);
        chk("rd_fields", fields_ok, 1);
        chk("rd_rsp_latency", rsp_n, 5);
        chk("rd_dat", o_rsp_dat, 32'h0000_0123);
        chk("rd_status", o_rsp_status, 2'b00);
        tick();

        // Silent slave: timeout after 8 cycles, late ack ignored
        slv_mode = 0; stall_cfg = 0;
        txn(1'b0, 2'd1, 32'h0, 4'hF, stbs, rsp_n, cyc_last, fields_ok);
        chk("to_stbs", stbs, 1);
        chk("to_cyc_last", cyc_last, 8);
        chk("to_rsp_latency", rsp_n, 9);
        chk("to_status", o_rsp_status, 2'b10);
        chk("to_dat", o_rsp_dat, 0);
        tick();
        tick();
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_late_ack_no_rsp", o_rsp_valid, 0);
            chk("to_late_ack_no_cyc", o_wb_cyc, 0);
            tick();
        end

        // err and ack together: err wins
        slv_mode = 2; rdata = 32'h5555_AAAA;
        txn(1'b0, 2'd3, 32'h0, 4'h3, stbs, rsp_n, cyc_last, fields_ok);
        chk("err_rsp_latency", rsp_n, 3);
        chk("err_status", o_rsp_status, 2'b01);
        chk("err_dat", o_rsp_dat, 0);
        tick();

        // rty on every attempt
        slv_mode = 3;
        txn(1'b1, 2'd1, 32'hCAFE_0001, 4'h1, stbs, rsp_n, cyc_last, fields_ok);
`ifdef WDG_WBM_RETRY_EN
        chk("rty_stbs", stbs, 4);
        chk("rty_rsp_latency", rsp_n, 12);
`else
        chk("rty_stbs", stbs, 1);
        chk("rty_rsp_latency", rsp_n, 3);
`endif
        chk("rty_fields", fields_ok, 1);
        chk("rty_status", o_rsp_status, 2'b11);
        chk("rty_dat", o_rsp_dat, 0);
        tick();

        // Response backpressure for 5 cycles
        slv_mode = 1; rdata = 32'hA5A5_0F0F; i_rsp_ready = 1'b0;
        txn(1'b0, 2'd1, 32'h0, 4'hF, stbs, rsp_n, cyc_last, fields_ok);
        chk("bp_dat", o_rsp_dat, 32'hA5A5_0F0F);
        chk("bp_status", o_rsp_status, 2'b00);
        held_dat = o_rsp_dat;
        held_st  = o_rsp_status;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_valid_held", o_rsp_valid, 1);
            chk("bp_dat_held", o_rsp_dat, 32'hA5A5_0F0F);
            chk("bp_status_held", o_rsp_status, held_st);
            chk("bp_cmd_ready_low", o_cmd_ready, 0);
        end
        chk("bp_dat_stable", o_rsp_dat, held_dat);
        i_rsp_ready = 1'b1;
        tick();
        chk("bp_released_valid", o_rsp_valid, 0);
        chk("bp_released_ready", o_cmd_ready, 1);

        // Reset asserted while in REQ
        stall_cfg = 1000;
        i_cmd_valid = 1'b1; i_cmd_we = 1'b1; i_cmd_adr = 2'd2;
        i_cmd_dat = 32'h1234_5678; i_cmd_sel = 4'hF;
        tick();
        i_cmd_valid = 1'b0;
        chk("rstmid_stb_before", o_wb_stb, 1);
        #2;
        res_n = 1'b0;
        #1;
        chk("rstmid_cyc_async", o_wb_cyc, 0);
        chk("rstmid_stb_async", o_wb_stb, 0);
        chk("rstmid_adr_async", o_wb_adr, 0);
        tick();
        tick();
        res_n = 1'b1;
        stall_cfg = 0;
        tick();
        chk("rstmid_cmd_ready", o_cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk("rstmid_no_rsp", o_rsp_valid, 0);
            chk("rstmid_no_cyc", o_wb_cyc, 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
